// File: rtl/video_byte_shifter.sv
// video_byte_shifter: fetches display bytes from video RAM and turns them
// into per-clock 2-bit colour indices, with border/blank codes outside the viewport.
module video_byte_shifter #(
    parameter int         ADDR_W      = 13,
    parameter logic [1:0] BORDER_CODE = 2'b00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [5:0]        width,
    input  logic              bpp2,
    input  logic [3:0]        line_rep,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              preload,
    input  logic [1:0]        active,
    input  logic              hsn,
    input  logic              fsn,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [1:0]        pixel,
    output logic [1:0]        pix_class,
    output logic              underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FULL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_fsn_d;
    logic              r_hsn_d;
    logic              r_pre_d;
    logic [ADDR_W-1:0] r_row_base;
    logic [3:0]        r_line_cnt;
    logic [5:0]        r_fetch_cnt;
    logic [7:0]        r_hold;
    logic              r_hold_full;
    logic [7:0]        r_shift;
    logic [3:0]        r_cnt;
    logic [1:0]        r_pixel;
    logic [1:0]        r_class;
    logic              r_underrun;

    logic              w_fs;
    logic              w_le;
    logic              w_pre_rise;
    logic              w_flush;
    logic              w_view;
    logic              w_load;
    logic              w_take;
    logic [3:0]        w_cpb_max;
    logic [3:0]        w_hold_mask;
    logic [7:0]        w_shift_cur;
    logic              w_shift_now;
    logic [1:0]        w_pix;
    logic [ADDR_W-1:0] w_width_ext;

    assign w_fs        = r_fsn_d & ~fsn;
    assign w_le        = r_hsn_d & ~hsn;
    assign w_pre_rise  = preload & ~r_pre_d;
    assign w_flush     = w_fs | w_le;
    assign w_view      = (active == 2'b11);
    assign w_load      = w_view && (r_cnt == 4'd0);
    assign w_take      = w_load && r_hold_full;
    assign w_width_ext = {{(ADDR_W-6){1'b0}}, width};
    assign mem_addr    = r_row_base + {{(ADDR_W-6){1'b0}}, r_fetch_cnt};
    assign w_shift_cur = w_load ? (r_hold_full ? r_hold : 8'h00) : r_shift;
    assign w_shift_now = ((r_cnt & w_hold_mask) == w_hold_mask);
    assign w_pix       = bpp2 ? w_shift_cur[7:6] : {2{w_shift_cur[7]}};
    assign pixel       = r_pixel;
    assign pix_class   = r_class;
    assign underrun    = r_underrun;

    // Clocks per byte and pixel-hold mask from row width and depth
    always_comb begin
        w_cpb_max   = (width == 6'd32) ? 4'd7 : 4'd15;
        w_hold_mask = 4'd3;
        case ({width == 6'd32, bpp2})
            2'b10:   w_hold_mask = 4'd0;
            2'b11:   w_hold_mask = 4'd1;
            2'b00:   w_hold_mask = 4'd1;
            default: w_hold_mask = 4'd3;
        endcase
    end

    // Edge-detect history for sync and preload inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsn_d <= 1'b1;
            r_hsn_d <= 1'b1;
            r_pre_d <= 1'b0;
        end else begin
            r_fsn_d <= fsn;
            r_hsn_d <= hsn;
            r_pre_d <= preload;
        end
    end

    // Row base and scanline repeat tracking; frame start beats line end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_base <= '0;
            r_line_cnt <= 4'd0;
        end else if (w_fs) begin
            r_row_base <= base_addr;
            r_line_cnt <= 4'd0;
        end else if (w_le) begin
            if (r_line_cnt == line_rep) begin
                r_line_cnt <= 4'd0;
                r_row_base <= r_row_base + w_width_ext;
            end else begin
                r_line_cnt <= r_line_cnt + 4'd1;
            end
        end
    end

    // Fetch state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Fetch next state and request strobe; sync events abort any fetch
    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        case (r_state)
            S_IDLE:  if (w_pre_rise) w_next = S_ISSUE;
            S_ISSUE: begin
                mem_req = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT:  if (mem_ack) w_next = S_FULL;
            S_FULL:  if (!r_hold_full)
                         w_next = (r_fetch_cnt < width) ? S_ISSUE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_flush) w_next = w_pre_rise ? S_ISSUE : S_IDLE;
    end

    // Holding register and fetch byte counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_fetch_cnt <= 6'd0;
        end else if (w_flush) begin
            r_hold_full <= 1'b0;
            r_fetch_cnt <= 6'd0;
        end else begin
            if (r_state == S_IDLE && w_pre_rise) r_fetch_cnt <= 6'd0;
            if (r_state == S_WAIT && mem_ack) begin
                r_hold      <= mem_data;
                r_hold_full <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 6'd1;
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Pixel shifter: load every cpb clocks in the viewport, shift per hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= 8'h00;
            r_cnt   <= 4'd0;
        end else if (w_flush) begin
            r_shift <= 8'h00;
            r_cnt   <= 4'd0;
        end else if (!w_view) begin
            r_cnt   <= 4'd0;
        end else begin
            if (w_shift_now)
                r_shift <= bpp2 ? {w_shift_cur[5:0], 2'b00}
                                : {w_shift_cur[6:0], 1'b0};
            else
                r_shift <= w_shift_cur;
            r_cnt <= (r_cnt == w_cpb_max) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // Sticky underrun: set on a load with no byte ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    r_underrun <= 1'b0;
        else if (w_fs)                   r_underrun <= 1'b0;
        else if (w_load && !r_hold_full) r_underrun <= 1'b1;
    end

    // Output stage: one register, class follows active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel <= 2'b00;
            r_class <= 2'b00;
        end else begin
            r_class <= active;
            case (active)
                2'b11:   r_pixel <= w_pix;
                2'b10:   r_pixel <= BORDER_CODE;
                default: r_pixel <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_video_byte_shifter.sv
// tb_video_byte_shifter: scoreboard bench for the video byte shifter,
// with a latency-programmable RAM model and a scripted frame timing source.
module tb_video_byte_shifter;
    localparam int         ADDR_W = 13;
    localparam logic [1:0] BCODE  = 2'b10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [5:0]        width;
    logic              bpp2;
    logic [3:0]        line_rep;
    logic [ADDR_W-1:0] base_addr;
    logic              preload;
    logic [1:0]        active;
    logic              hsn;
    logic              fsn;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [1:0]        pixel;
    logic [1:0]        pix_class;
    logic              underrun;

    always #5 clk = ~clk;

    video_byte_shifter #(.ADDR_W(ADDR_W), .BORDER_CODE(BCODE)) dut (
        .clk(clk), .reset_n(reset_n), .width(width), .bpp2(bpp2),
        .line_rep(line_rep), .base_addr(base_addr), .preload(preload),
        .active(active), .hsn(hsn), .fsn(fsn), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .pixel(pixel), .pix_class(pix_class), .underrun(underrun)
    );

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [ADDR_W-1:0] q_addr[$];
    logic [3:0]        q_pix[$];
    int                ack_lat = 2;
    int                ack_cnt = 0;
    logic [7:0]        ram_val = 8'h00;
    logic [1:0]        act_seen = 2'b00;
    logic [1:0]        exp_seq[16];
    int                ur_byte = 1000;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // RAM model: answers each request ack_lat clocks later with ram_val
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (ack_cnt != 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = ram_val;
            end
        end
        if (mem_req) ack_cnt = ack_lat;
    end

    always @(posedge clk) act_seen <= reset_n ? active : 2'b00;

    // Monitor: pops expected addresses and pixels as the DUT presents them
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req) begin
                check("addr expected", int'(q_addr.size() != 0), 1);
                if (q_addr.size() != 0)
                    check("mem_addr", int'(mem_addr), int'(q_addr.pop_front()));
            end
            check("pix_class lag", int'(pix_class), int'(act_seen));
            if (pix_class == 2'b00) begin
                check("blank pixel", int'(pixel), 0);
            end else begin
                check("pixel expected", int'(q_pix.size() != 0), 1);
                if (q_pix.size() != 0)
                    check("class/pixel", int'({pix_class, pixel}),
                          int'(q_pix.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] p);
        active = a;
        if (a != 2'b00) q_pix.push_back({a, p});
        step(1);
    endtask

    task automatic frame();
        fsn = 1'b0;
        step(2);
        fsn = 1'b1;
        step(2);
    endtask

    task automatic run_line(input int nbytes, input int cpb, input int gap);
        preload = 1'b1;
        step(4);
        preload = 1'b0;
        step(gap);
        drive(2'b10, BCODE);
        drive(2'b10, BCODE);
        for (int b = 0; b < nbytes; b++)
            for (int k = 0; k < cpb; k++)
                drive(2'b11, (b >= ur_byte) ? 2'b00 : exp_seq[k]);
        drive(2'b10, BCODE);
        drive(2'b10, BCODE);
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b00);
        hsn = 1'b0;
        step(2);
        hsn = 1'b1;
        step(2);
    endtask

    initial begin
        reset_n   = 1'b0;
        width     = 6'd32;
        bpp2      = 1'b0;
        line_rep  = 4'd0;
        base_addr = '0;
        preload   = 1'b0;
        active    = 2'b00;
        hsn       = 1'b1;
        fsn       = 1'b1;
        mem_ack   = 1'b0;
        mem_data  = 8'h00;
        step(3);
        check("reset mem_req", int'(mem_req), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset pixel", int'(pixel), 0);
        check("reset pix_class", int'(pix_class), 0);
        check("reset underrun", int'(underrun), 0);
        reset_n = 1'b1;
        step(2);

        // Reset while a slow fetch is outstanding
        base_addr = 13'h0123;
        ack_lat   = 20;
        ram_val   = 8'h55;
        frame();
        q_addr.push_back(13'h0123);
        preload = 1'b1;
        step(2);
        preload = 1'b0;
        drive(2'b10, BCODE);
        drive(2'b10, BCODE);
        drive(2'b10, BCODE);
        active = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        check("abort mem_req", int'(mem_req), 0);
        check("abort mem_addr", int'(mem_addr), 0);
        check("abort pixel", int'(pixel), 0);
        check("abort pix_class", int'(pix_class), 0);
        check("abort underrun", int'(underrun), 0);
        q_pix.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
        check("post-release mem_req", int'(mem_req), 0);
        step(30);

        // width 32, 1bpp, 0xA5 at 0x0400
        width     = 6'd32;
        bpp2      = 1'b0;
        line_rep  = 4'd0;
        base_addr = 13'h0400;
        ack_lat   = 2;
        ram_val   = 8'hA5;
        exp_seq   = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3,
                      2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        frame();
        for (int i = 0; i < 32; i++)
            q_addr.push_back(ADDR_W'(32'h0400 + i));
        run_line(32, 8, 6);
        check("w32 underrun", int'(underrun), 0);

        // width 16, 2bpp, 0x1B, two scanlines per row
        width    = 6'd16;
        bpp2     = 1'b1;
        line_rep = 4'd1;
        ram_val  = 8'h1B;
        exp_seq  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                     2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        frame();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 16; i++)
                q_addr.push_back(ADDR_W'(32'h0400 + i));
            run_line(16, 16, 6);
        end
        q_addr.push_back(13'h0410);
        q_addr.push_back(13'h0411);
        run_line(1, 16, 6);
        check("w16 underrun", int'(underrun), 0);

        // Row base advance every third line, wrapping past 0x1FFF
        width     = 6'd32;
        bpp2      = 1'b0;
        line_rep  = 4'd2;
        base_addr = 13'h1FF0;
        ram_val   = 8'h3C;
        exp_seq   = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0,
                      2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        frame();
        for (int l = 0; l < 6; l++) begin
            q_addr.push_back((l < 3) ? 13'h1FF0 : 13'h0010);
            q_addr.push_back((l < 3) ? 13'h1FF1 : 13'h0011);
            run_line(1, 8, 6);
        end

        // Slow RAM: second byte misses its load point
        line_rep  = 4'd0;
        base_addr = 13'h0800;
        ack_lat   = 20;
        ram_val   = 8'hFF;
        exp_seq   = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                      2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        frame();
        check("pre-underrun flag", int'(underrun), 0);
        q_addr.push_back(13'h0800);
        q_addr.push_back(13'h0801);
        ur_byte = 1;
        run_line(2, 8, 30);
        ur_byte = 1000;
        check("underrun set", int'(underrun), 1);
        step(5);
        check("underrun sticky", int'(underrun), 1);
        frame();
        check("underrun cleared", int'(underrun), 0);
        step(30);

        check("addr queue drained", q_addr.size(), 0);
        check("pixel queue drained", q_pix.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
